// File: rtl/shift_reg_ctrl_pkg.sv
// shift_reg_ctrl_pkg: FSM state encoding and default WIDTH/TAPS for the delay-line controller
package shift_reg_ctrl_pkg;
  localparam int DEF_WIDTH = 7;
  localparam int DEF_TAPS = 8;
  typedef enum logic [2:0] {IDLE, SHIFT, SCAN, DONE, FLUSH} state_e;
endpackage

// File: rtl/shift_reg_ctrl_if.sv
// shift_reg_ctrl_if: controller bundle (in_valid/in_data/in_ready, flush, shift_en/shift_data, tap_sel/tap_valid/tap_last, out_valid/out_ready, busy, sample_cnt)
interface shift_reg_ctrl_if import shift_reg_ctrl_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CW = $clog2(DEF_TAPS)
);
  logic in_valid;
  logic [WIDTH-1:0] in_data;
  logic in_ready;
  logic flush;
  logic shift_en;
  logic [WIDTH-1:0] shift_data;
  logic [CW-1:0] tap_sel;
  logic tap_valid;
  logic tap_last;
  logic out_valid;
  logic out_ready;
  logic busy;
  logic [15:0] sample_cnt;
  modport master (
    output in_valid, in_data, flush, out_ready,
    input in_ready, shift_en, shift_data, tap_sel, tap_valid, tap_last, out_valid, busy, sample_cnt
  );
  modport slave (
    input in_valid, in_data, flush, out_ready,
    output in_ready, shift_en, shift_data, tap_sel, tap_valid, tap_last, out_valid, busy, sample_cnt
  );
endinterface

// File: rtl/shift_reg_ctrl_tap.sv
// tap_counter: tap index counter (clr_i loads 0, en_i counts, wraps to 0 after tc_o at TAPS-1); ports clk, rst, clr_i, en_i, cnt_o, tc_o
module tap_counter import shift_reg_ctrl_pkg::*; #(
  parameter int TAPS = DEF_TAPS,
  parameter int CW = $clog2(TAPS)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic [CW-1:0] cnt_o,
  output logic tc_o
);
  logic [CW-1:0] cnt_q, cnt_d;
  assign tc_o = cnt_q == CW'(TAPS - 1);
  assign cnt_o = cnt_q;
  always_comb cnt_d = (clr_i || (en_i && tc_o)) ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/shift_reg_ctrl.sv
// shift_reg_ctrl: accept a sample, shift it into an external delay line, scan all taps, hand off the result; ports clk, rst, bus (slave bundle)
module shift_reg_ctrl import shift_reg_ctrl_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TAPS = DEF_TAPS,
  parameter int CW = $clog2(TAPS)
) (
  input logic clk,
  input logic rst,
  shift_reg_ctrl_if.slave bus
);
  state_e state_q, state_d;
  logic [WIDTH-1:0] shift_data_q, shift_data_d;
  logic [15:0] sample_cnt_q, sample_cnt_d;
  logic [CW-1:0] cnt;
  logic tc, run;
  // SCAN and FLUSH share the counter; it sits at 0 in every other state
  assign run = state_q == SCAN || state_q == FLUSH;
  tap_counter #(.TAPS(TAPS), .CW(CW)) u_tap (
    .clk(clk), .rst(rst), .clr_i(!run), .en_i(run), .cnt_o(cnt), .tc_o(tc)
  );
  always_comb begin
    state_d = state_q;
    shift_data_d = shift_data_q;
    sample_cnt_d = sample_cnt_q;
    case (state_q)
      IDLE:
        if (bus.flush) begin
          state_d = FLUSH;
          shift_data_d = '0;
        end else if (bus.in_valid) begin
          state_d = SHIFT;
          shift_data_d = bus.in_data;
        end
      SHIFT: state_d = SCAN;
      SCAN: state_d = tc ? DONE : SCAN;
      DONE:
        if (bus.out_ready) begin
          state_d = IDLE;
          sample_cnt_d = sample_cnt_q + 1'b1;
        end
      FLUSH: state_d = tc ? IDLE : FLUSH;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    state_q <= rst ? IDLE : state_d;
    shift_data_q <= rst ? '0 : shift_data_d;
    sample_cnt_q <= rst ? '0 : sample_cnt_d;
  end
  assign bus.in_ready = state_q == IDLE && !bus.flush && !rst;
  assign bus.shift_en = state_q == SHIFT || state_q == FLUSH;
  assign bus.shift_data = shift_data_q;
  assign bus.tap_valid = state_q == SCAN;
  assign bus.tap_sel = state_q == SCAN ? cnt : '0;
  assign bus.tap_last = state_q == SCAN && tc;
  assign bus.out_valid = state_q == DONE;
  assign bus.busy = state_q != IDLE;
  assign bus.sample_cnt = sample_cnt_q;
endmodule

// File: tb/tb_shift_reg_ctrl.sv
// tb_shift_reg_ctrl: randomized self-checking bench for shift_reg_ctrl against a cycle-timeline model
module tb_shift_reg_ctrl;
  localparam int W = 7;
  localparam int T = 8;
  localparam int C = $clog2(T);
  typedef logic [W+C+5:0] vec_t;
  logic clk = 1'b0;
  logic rst;
  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int se_cnt = 0;
  int last_sc = 0;
  logic [15:0] exp_cnt = '0;
  shift_reg_ctrl_if #(.WIDTH(W), .CW(C)) bus ();
  shift_reg_ctrl #(.WIDTH(W), .TAPS(T), .CW(C)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.shift_en) se_cnt <= se_cnt + 1;
  function automatic vec_t obs();
    return {bus.shift_en, bus.shift_en ? bus.shift_data : {W{1'b0}}, bus.tap_valid,
            bus.tap_valid ? bus.tap_sel : {C{1'b0}}, bus.tap_last, bus.out_valid, bus.busy, bus.in_ready};
  endfunction
  function automatic vec_t ev(logic se, logic [W-1:0] sd, logic tv, logic [C-1:0] ts,
                              logic tl, logic ov, logic bz, logic ir);
    return {se, sd, tv, ts, tl, ov, bz, ir};
  endfunction
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  task automatic do_sample(input logic [W-1:0] d, input int hold, input string nm);
    vec_t e;
    bus.in_valid = 1'b1;
    bus.in_data = d;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    e = ev(0, 0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (obs() !== e) begin errs++; $display("FAIL %s accept got %h want %h", nm, obs(), e); end
    nxt();
    bus.in_valid = 1'($urandom_range(0, 1));
    bus.in_data = W'($urandom);
    bus.flush = 1'($urandom_range(0, 1));
    #1;
    last_sc = cyc;
    e = ev(1, d, 0, 0, 0, 0, 1, 0);
    checks++;
    if (obs() !== e) begin errs++; $display("FAIL %s shift got %h want %h", nm, obs(), e); end
    for (int k = 0; k < T; k++) begin
      nxt();
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.flush = 1'($urandom_range(0, 1));
      #1;
      e = ev(0, 0, 1, C'(k), k == T - 1, 0, 1, 0);
      checks++;
      if (obs() !== e) begin errs++; $display("FAIL %s scan%0d got %h want %h", nm, k, obs(), e); end
    end
    for (int h = 0; h <= hold; h++) begin
      nxt();
      bus.out_ready = h == hold;
      bus.in_valid = h == hold ? 1'b0 : 1'($urandom_range(0, 1));
      bus.flush = h == hold ? 1'b0 : 1'($urandom_range(0, 1));
      #1;
      e = ev(0, 0, 0, 0, 0, 1, 1, 0);
      checks++;
      if (obs() !== e) begin errs++; $display("FAIL %s done%0d got %h want %h", nm, h, obs(), e); end
      if (h == 0) begin
        checks++;
        if (bus.tap_sel !== '0) begin errs++; $display("FAIL %s done_tap_sel got %0d want 0", nm, bus.tap_sel); end
      end
    end
    exp_cnt++;
    nxt();
    bus.out_ready = 1'b0;
    #1;
    e = ev(0, 0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (obs() !== e) begin errs++; $display("FAIL %s idle got %h want %h", nm, obs(), e); end
    checks++;
    if (bus.sample_cnt !== exp_cnt) begin errs++; $display("FAIL %s sample_cnt got %h want %h", nm, bus.sample_cnt, exp_cnt); end
  endtask
  task automatic do_flush(input logic v, input string nm);
    vec_t e;
    bus.flush = 1'b1;
    bus.in_valid = v;
    bus.in_data = W'($urandom);
    bus.out_ready = 1'b0;
    #1;
    e = ev(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs() !== e) begin errs++; $display("FAIL %s req got %h want %h", nm, obs(), e); end
    for (int k = 0; k < T; k++) begin
      nxt();
      bus.flush = k == T - 1 ? 1'b0 : 1'($urandom_range(0, 1));
      #1;
      e = ev(1, 0, 0, 0, 0, 0, 1, 0);
      checks++;
      if (obs() !== e) begin errs++; $display("FAIL %s zero%0d got %h want %h", nm, k, obs(), e); end
    end
    nxt();
    #1;
    e = ev(0, 0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (obs() !== e) begin errs++; $display("FAIL %s idle got %h want %h", nm, obs(), e); end
    checks++;
    if (bus.sample_cnt !== exp_cnt) begin errs++; $display("FAIL %s sample_cnt got %h want %h", nm, bus.sample_cnt, exp_cnt); end
  endtask
  task automatic test_reset();
    logic [W+C+21:0] rv;
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = W'(5);
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    nxt();
    nxt();
    rv = {bus.shift_en, bus.shift_data, bus.tap_sel, bus.tap_valid, bus.tap_last,
          bus.out_valid, bus.busy, bus.sample_cnt, bus.in_ready};
    checks++;
    if (rv !== '0) begin errs++; $display("FAIL reset_values got %h want 0", rv); end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL reset_release in_ready got %b want 1", bus.in_ready); end
    exp_cnt = '0;
  endtask
  task automatic test_single();
    do_sample(W'(3), 0, "single");
  endtask
  task automatic test_backpressure();
    do_sample(W'($urandom), 5, "backpressure");
  endtask
  task automatic test_stream();
    int vals[5] = '{1, 5, 11, 15, 21};
    int se0, prev;
    logic [15:0] c0;
    se0 = se_cnt;
    c0 = bus.sample_cnt;
    prev = 0;
    foreach (vals[i]) begin
      do_sample(W'(vals[i]), 0, "stream");
      if (i > 0) begin
        checks++;
        if (last_sc - prev != T + 3) begin errs++; $display("FAIL stream_period got %0d want %0d", last_sc - prev, T + 3); end
      end
      prev = last_sc;
    end
    checks++;
    if (se_cnt - se0 != 5) begin errs++; $display("FAIL stream_pulses got %0d want 5", se_cnt - se0); end
    checks++;
    if (bus.sample_cnt !== c0 + 16'd5) begin errs++; $display("FAIL stream_cnt got %h want %h", bus.sample_cnt, c0 + 16'd5); end
  endtask
  task automatic test_flush_vs_valid();
    int se0;
    logic [W-1:0] pend;
    pend = W'($urandom);
    se0 = se_cnt;
    do_flush(1'b1, "flush_vs_valid");
    checks++;
    if (se_cnt - se0 != T) begin errs++; $display("FAIL flush_pulses got %0d want %0d", se_cnt - se0, T); end
    do_sample(pend, 0, "flush_pending");
  endtask
  task automatic test_reset_mid_scan();
    logic [W+C+21:0] rv;
    bus.in_valid = 1'b1;
    bus.in_data = W'(9);
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    nxt();
    bus.in_valid = 1'b0;
    repeat (5) nxt();
    #1;
    checks++;
    if (bus.tap_sel !== C'(4) || bus.tap_valid !== 1'b1) begin errs++; $display("FAIL mid_scan_tap got %0d/%b want 4/1", bus.tap_sel, bus.tap_valid); end
    rst = 1'b1;
    nxt();
    #1;
    rv = {bus.shift_en, bus.shift_data, bus.tap_sel, bus.tap_valid, bus.tap_last,
          bus.out_valid, bus.busy, bus.sample_cnt, bus.in_ready};
    checks++;
    if (rv !== '0) begin errs++; $display("FAIL mid_scan_reset got %h want 0", rv); end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL mid_scan_release in_ready got %b want 1", bus.in_ready); end
    exp_cnt = '0;
  endtask
  task automatic test_reset_mid_flush();
    bus.flush = 1'b1;
    nxt();
    bus.flush = 1'b0;
    nxt();
    nxt();
    rst = 1'b1;
    nxt();
    #1;
    checks++;
    if ({bus.busy, bus.shift_en, bus.in_ready} !== 3'b000) begin errs++; $display("FAIL mid_flush_reset busy/shift_en/in_ready got %b want 000", {bus.busy, bus.shift_en, bus.in_ready}); end
    rst = 1'b0;
    #1;
    exp_cnt = '0;
    do_sample(W'($urandom), 1, "after_flush_reset");
  endtask
  task automatic test_random();
    vec_t e;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 4) == 0) do_flush(1'($urandom_range(0, 1)), "rand_flush");
      else do_sample(W'($urandom), int'($urandom_range(0, 3)), "rand_sample");
      repeat ($urandom_range(0, 2)) begin
        bus.in_valid = 1'b0;
        bus.flush = 1'b0;
        nxt();
        #1;
        e = ev(0, 0, 0, 0, 0, 0, 0, 1);
        checks++;
        if (obs() !== e) begin errs++; $display("FAIL rand_gap got %h want %h", obs(), e); end
      end
    end
  endtask
  task automatic test_wrap();
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    // a real run to 16'hFFFE would need ~720k cycles, so the counter is preloaded instead
    force dut.sample_cnt_q = 16'hFFFE;
    nxt();
    release dut.sample_cnt_q;
    #1;
    exp_cnt = 16'hFFFE;
    checks++;
    if (bus.sample_cnt !== 16'hFFFE) begin errs++; $display("FAIL wrap_preload got %h want fffe", bus.sample_cnt); end
    do_sample(W'($urandom), 0, "wrap_ffff");
    checks++;
    if (bus.sample_cnt !== 16'hFFFF) begin errs++; $display("FAIL wrap_to_ffff got %h want ffff", bus.sample_cnt); end
    do_sample(W'($urandom), 0, "wrap_zero");
    checks++;
    if (bus.sample_cnt !== 16'h0000) begin errs++; $display("FAIL wrap_to_zero got %h want 0000", bus.sample_cnt); end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d want completion", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_stream();
    test_flush_vs_valid();
    test_reset_mid_scan();
    test_reset_mid_flush();
    test_random();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/shift_reg_ctrl.md
SHIFT_REG_CTRL -- requirements
Module: shift_reg_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 7, giving the sample width in bits.
REQ-002 The block SHALL have parameter TAPS, default 8, giving the delay-line depth; legal range 2..256.
REQ-003 The block SHALL have parameter CW, default $clog2(TAPS), giving the tap_sel width.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  reset, synchronous and active-high.
REQ-006 Port in_valid  input  1  upstream sample present.
REQ-007 Port in_data  input  WIDTH  upstream sample.
REQ-008 Port in_ready  output  1  controller accepts a sample this cycle.
REQ-009 Port flush  input  1  request to zero-fill the delay line.
REQ-010 Port shift_en  output  1  shift strobe to the external shift register.
REQ-011 Port shift_data  output  WIDTH  data presented to the shift register data_in.
REQ-012 Port tap_sel  output  CW  tap index for the downstream serial MAC.
REQ-013 Port tap_valid  output  1  tap_sel is valid this cycle.
REQ-014 Port tap_last  output  1  current tap is TAPS-1.
REQ-015 Port out_valid  output  1  pass complete; result ready downstream.
REQ-016 Port out_ready  input  1  downstream accepts the result.
REQ-017 Port busy  output  1  high in every state except IDLE.
REQ-018 Port sample_cnt  output  16  count of completed out handshakes.

Function
REQ-019 The FSM SHALL have states IDLE, SHIFT, SCAN, DONE and FLUSH.
REQ-020 in_ready SHALL be combinational: (state==IDLE) && !flush.
REQ-021 In IDLE, if flush=1, the FSM SHALL go to FLUSH; flush has priority over in_valid, and no handshake occurs that cycle.
REQ-022 In IDLE, if in_valid && in_ready, in_data SHALL be registered into shift_data and the FSM SHALL go to SHIFT.
REQ-023 SHIFT SHALL last exactly one cycle with shift_en=1, then go to SCAN with tap_sel=0.
REQ-024 In SCAN, tap_valid SHALL be 1, tap_sel SHALL increment by 1 per cycle from 0 to TAPS-1, and tap_last SHALL be 1 only when tap_sel==TAPS-1.
REQ-025 After the tap_last cycle the FSM SHALL go to DONE; tap_sel SHALL then return to 0 with tap_valid=0.
REQ-026 In DONE, out_valid SHALL be held at 1 until out_ready=1; on that handshake cycle the FSM SHALL go to IDLE and sample_cnt SHALL increment.
REQ-027 sample_cnt SHALL wrap from 16'hFFFF to 0.
REQ-028 Latency: with handshake at cycle 0, shift_en is high at cycle 1, tap_sel=0 at cycle 2, tap_last at cycle TAPS+1, and out_valid first high at cycle TAPS+2.
REQ-029 FLUSH SHALL drive shift_data=0 and shift_en=1 for exactly TAPS consecutive cycles, counted by the tap counter, then go to IDLE without asserting out_valid or changing sample_cnt.
REQ-030 flush asserted outside IDLE SHALL be ignored; it is not queued.
REQ-031 shift_en SHALL never be high in IDLE, SCAN or DONE.
REQ-032 Minimum sample period SHALL be TAPS+3 cycles (out_ready tied high).

Reset
REQ-033 When rst=1 at a clock edge, the FSM SHALL enter IDLE from any state, including mid-SCAN and mid-FLUSH.
REQ-034 Reset values SHALL be: shift_en=0, shift_data=0, tap_sel=0, tap_valid=0, tap_last=0, out_valid=0, busy=0, sample_cnt=0.
REQ-035 During rst=1, in_ready SHALL be 0, and in_ready SHALL follow REQ-020 from the first cycle after reset is released.

Structure
REQ-036 State encodings and the default TAPS/WIDTH constants SHALL live in the shared package shift_reg_ctrl_pkg.
REQ-037 The tap counter (load 0, enable, terminal-count flag at TAPS-1) SHALL be a sub-module named tap_counter, shared by SCAN and FLUSH.
REQ-038 The shift register itself is external; shift_data and shift_en connect directly to its data_in and enable.

Verification
REQ-039 Reset mid-SCAN: assert rst at tap_sel=4 -> next cycle IDLE, all outputs at reset values, in_ready=1 after release.
REQ-040 Single sample: WIDTH=7, TAPS=8, in_data=7'd3 accepted at cycle 0 -> shift_data=3 and shift_en=1 at cycle 1, tap_sel 0..7 at cycles 2..9, tap_last at cycle 9, out_valid at cycle 10, sample_cnt=1 after the handshake.
REQ-041 Back-pressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, in_ready stays 0, no shift_en; release -> IDLE on the next cycle.
REQ-042 Stream: samples 1,5,11,15,21 with out_ready=1 -> exactly 5 shift_en pulses spaced 11 cycles apart, sample_cnt=5.
REQ-043 Flush vs. valid: flush=1 and in_valid=1 in the same IDLE cycle -> in_ready=0, 8 consecutive shift_en with shift_data=0, no out_valid, then the pending sample is accepted in IDLE.
REQ-044 Wrap: preload sample_cnt near 16'hFFFF via a run of samples -> the handshake after 16'hFFFF yields 0.
